multdiv_ctrl: RTL and testbench
===============================

# multdiv_ctrl

Sequencer that owns the multi-cycle multiplier/divider on behalf of the 5-stage pipeline. It sits beside the DX stage. When a `mul`/`div` reaches DX, it latches the operands, issues a one-cycle start pulse to the unit, and holds the pipeline stall until the unit reports ready or a timeout expires. It then presents the result and an rstatus code for the DX→XM latch.

## Interface
- MAX_CYCLES, 40, BUSY cycles allowed before abort; must be ≥ 2.
- clock  in  1  master clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- dx_valid  in  1  DX holds a real (non-bubble) instruction
- dx_is_mult  in  1  DX opcode/ALU-op decodes to mul
- dx_is_div  in  1  DX opcode/ALU-op decodes to div; never asserted together with dx_is_mult
- operand_a  in  32  bypassed ALU input A for the DX instruction
- operand_b  in  32  bypassed ALU input B for the DX instruction
- flush  in  1  DX instruction is being squashed this cycle
- unit_result  in  32  multdiv result
- unit_exception  in  1  overflow or divide-by-zero
- unit_resultRDY  in  1  unit result valid
- ctrl_MULT  out  1  one-cycle start pulse, multiply
- ctrl_DIV  out  1  one-cycle start pulse, divide
- unit_A  out  32  registered operand A to unit
- unit_B  out  32  registered operand B to unit
- stall  out  1  1 = hold PC/FD/DX/XM/MW enables
- result_valid  out  1  result/result_status valid; DX→XM latch captures this cycle
- result  out  32  captured product/quotient
- result_status  out  3  0 ok, 4 mult exception, 5 div exception, 6 timeout

## Operation
- FSM states: IDLE, START, BUSY, DONE. Registers: state, op_is_div, operands, counter, result, status.
- IDLE:
  - accept = dx_valid & (dx_is_mult | dx_is_div) & ~flush.
  - stall = accept (combinational).
  - On accept: latch operand_a/b → unit_A/B and the op type, then go to START.
- START:
  - stall = 1.
  - Registered ctrl_MULT or ctrl_DIV high for exactly this cycle, per the latched type.
  - Counter cleared. Go to BUSY.
  - unit_resultRDY is ignored in this state.
- BUSY:
  - stall = 1; counter increments each cycle.
  - On unit_resultRDY: capture unit_result, set status to 0, or to 4/5 if unit_exception. Go to DONE.
  - Otherwise, when counter == MAX_CYCLES-1: result = 0, status = 6, go to DONE.
  - RDY and timeout in the same cycle: RDY wins.
- DONE:
  - stall = 0; result_valid = 1.
  - The pipeline advances the DX instruction into XM with result/result_status.
  - Go to IDLE. The next DX instruction is evaluated in the following IDLE cycle, so back-to-back mul/div restart cleanly and the same instruction is never re-accepted.
- flush:
  - In START or BUSY, go to IDLE next edge; no result_valid, stall drops.
  - The unit is left running and is restarted by the next start pulse.
  - In DONE, flush is ignored.
- result and result_status hold their values until the next capture.
- counter width is $clog2(MAX_CYCLES+1); it saturates and never wraps.

## Timing
- Reset values: state IDLE, ctrl_MULT/ctrl_DIV 0, unit_A/B 0, result 0, result_status 0, result_valid 0, counter 0. stall is forced 0 while reset = 0.
- Reset mid-operation: immediate return to IDLE, all outputs as above; no pulse is re-issued after release.
- Unit reporting RDY k cycles after the start pulse (k ≥ 1): stall is high for k+2 cycles (accept, START, k BUSY cycles). result_valid follows in the next cycle.
- Timeout: stall is high for MAX_CYCLES+2 cycles.
- All outputs except IDLE-state stall are registered.

## Structure
- Shared package multdiv_pkg: state enum (IDLE, START, BUSY, DONE), status constants (STAT_OK 0, STAT_MULT 4, STAT_DIV 5, STAT_TIMEOUT 6), MAX_CYCLES default.
- Single module; the counter is inline and no sub-module is warranted.
- The bench uses a behavioural multdiv model with a programmable RDY delay.

## Test plan
- mul 7×6, RDY delay 16: one ctrl_MULT pulse, stall high 18 cycles, then result_valid with result 42, status 0.
- div 100÷0, unit_exception on RDY: result_valid with status 5, ctrl_DIV pulsed once, ctrl_MULT never pulsed.
- Model never asserts RDY, MAX_CYCLES 40: stall high 42 cycles, then result 0, status 6.
- Back-to-back mul then div: two distinct pulses, two result_valid cycles, with exactly one IDLE cycle between operations.
- flush during BUSY: no result_valid, stall low next cycle, FSM in IDLE.
- reset driven low mid-BUSY: all outputs 0 within the same cycle; after release, no spurious pulse and FSM in IDLE.

Source files
------------

// File: rtl/multdiv_pkg.sv
`timescale 1ns/1ps
// multdiv_pkg
// Shared definitions for the multiply/divide sequencer:
//   state_t          - sequencer FSM encoding (IDLE, START, BUSY, DONE)
//   STAT_*           - result_status codes presented to the DX->XM latch
//   MAX_CYCLES_DEF   - default BUSY-cycle budget before the operation is aborted
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] STAT_OK      = 3'd0;
    localparam logic [2:0] STAT_MULT    = 3'd4;
    localparam logic [2:0] STAT_DIV     = 3'd5;
    localparam logic [2:0] STAT_TIMEOUT = 3'd6;

    localparam int MAX_CYCLES_DEF = 40;

endpackage

// File: rtl/multdiv_ctrl.sv
`timescale 1ns/1ps
// multdiv_ctrl
// Sequencer that owns the multi-cycle multiplier/divider for the DX stage.
// A mul/div in DX is accepted, its operands are latched and a one-cycle start
// pulse is sent to the unit; the pipeline is stalled until the unit reports
// ready or MAX_CYCLES BUSY cycles elapse. The result and a status code are then
// presented for one cycle (result_valid) so the DX->XM latch can capture them.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   dx_valid              DX holds a real instruction
//   dx_is_mult/dx_is_div  DX instruction is a mul / div (mutually exclusive)
//   operand_a/operand_b   bypassed ALU inputs of the DX instruction
//   flush                 DX instruction is squashed this cycle
//   unit_result           result from the multdiv unit
//   unit_exception        overflow / divide-by-zero from the unit
//   unit_resultRDY        unit result valid
//   ctrl_MULT/ctrl_DIV    one-cycle start pulses to the unit
//   unit_A/unit_B         registered operands to the unit
//   stall                 hold PC/FD/DX/XM/MW enables
//   result_valid          result/result_status valid this cycle
//   result                captured product/quotient (held until next capture)
//   result_status         0 ok, 4 mult exception, 5 div exception, 6 timeout
//   o_dbg_state           current FSM state for observation
//
// Handshake: the unit is started by a single-cycle ctrl_MULT/ctrl_DIV pulse and
// answers with unit_resultRDY, which is sampled only in BUSY; result_valid is a
// single-cycle strobe with no back-pressure, the pipeline always takes it.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int MAX_CYCLES = MAX_CYCLES_DEF   // must be >= 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dx_valid,
    input  logic        dx_is_mult,
    input  logic        dx_is_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    input  logic [31:0] unit_result,
    input  logic        unit_exception,
    input  logic        unit_resultRDY,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] unit_A,
    output logic [31:0] unit_B,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [2:0]  result_status,
    output state_t      o_dbg_state
);

    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYCLES - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic            r_is_div;
    logic [31:0]     r_unit_a;
    logic [31:0]     r_unit_b;
    logic            r_ctrl_mult;
    logic            r_ctrl_div;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_result;
    logic [2:0]      r_status;
    logic            r_result_valid;

    logic            w_accept;
    logic            w_stall;
    logic            w_load;
    logic            w_cnt_clr;
    logic            w_cnt_inc;
    logic            w_cap_rdy;
    logic            w_cap_to;

    assign w_accept = dx_valid & (dx_is_mult | dx_is_div) & ~flush;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_load       = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_cap_rdy    = 1'b0;
        w_cap_to     = 1'b0;
        case (r_state)
            IDLE: begin
                // The only combinational stall: the pipeline must hold the
                // accepting instruction in the very cycle it is decoded.
                w_stall = w_accept;
                if (w_accept) begin
                    w_load       = 1'b1;
                    w_next_state = START;
                end
            end
            START: begin
                // RDY is ignored here; it could only be a leftover from an
                // operation abandoned by flush or reset.
                w_stall   = 1'b1;
                w_cnt_clr = 1'b1;
                w_next_state = flush ? IDLE : BUSY;
            end
            BUSY: begin
                w_stall   = 1'b1;
                w_cnt_inc = 1'b1;
                if (flush) begin
                    w_next_state = IDLE;
                end else if (unit_resultRDY) begin
                    // RDY takes priority over a coincident timeout
                    w_cap_rdy    = 1'b1;
                    w_next_state = DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_cap_to     = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                // Flush is ignored: the instruction is leaving DX this cycle.
                // Returning to IDLE before re-evaluating DX prevents the same
                // instruction from being accepted twice.
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand latch and start pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_is_div    <= 1'b0;
            r_unit_a    <= '0;
            r_unit_b    <= '0;
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
        end else begin
            // Pulses are set only on the accept edge, so they are high for
            // exactly the START cycle.
            r_ctrl_mult <= w_load & ~dx_is_div;
            r_ctrl_div  <= w_load & dx_is_div;
            if (w_load) begin
                r_is_div <= dx_is_div;
                r_unit_a <= operand_a;
                r_unit_b <= operand_b;
            end
        end
    end

    // BUSY cycle counter; saturates instead of wrapping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc && (r_cnt != {CW{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Result capture; result and status hold until the next capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_result       <= '0;
            r_status       <= STAT_OK;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= w_cap_rdy | w_cap_to;
            if (w_cap_rdy) begin
                r_result <= unit_result;
                if (unit_exception) begin
                    r_status <= r_is_div ? STAT_DIV : STAT_MULT;
                end else begin
                    r_status <= STAT_OK;
                end
            end else if (w_cap_to) begin
                r_result <= '0;
                r_status <= STAT_TIMEOUT;
            end
        end
    end

    assign ctrl_MULT     = r_ctrl_mult;
    assign ctrl_DIV      = r_ctrl_div;
    assign unit_A        = r_unit_a;
    assign unit_B        = r_unit_b;
    // Gate with reset so the IDLE-state combinational stall is forced low
    // while reset is asserted.
    assign stall         = w_stall & reset;
    assign result_valid  = r_result_valid;
    assign result        = r_result;
    assign result_status = r_status;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_multdiv_ctrl.sv
`timescale 1ns/1ps
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  always #5 clock = ~clock;

  logic        dx_valid, dx_is_mult, dx_is_div, flush;
  logic [31:0] operand_a, operand_b;
  logic [31:0] unit_result;
  logic        unit_exception, unit_resultRDY;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] unit_A, unit_B;
  logic        stall, result_valid;
  logic [31:0] result;
  logic [2:0]  result_status;
  state_t      dbg_state;

  multdiv_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .dx_valid       (dx_valid),
    .dx_is_mult     (dx_is_mult),
    .dx_is_div      (dx_is_div),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .flush          (flush),
    .unit_result    (unit_result),
    .unit_exception (unit_exception),
    .unit_resultRDY (unit_resultRDY),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .unit_A         (unit_A),
    .unit_B         (unit_B),
    .stall          (stall),
    .result_valid   (result_valid),
    .result         (result),
    .result_status  (result_status),
    .o_dbg_state    (dbg_state)
  );

  // ---------------- counters / scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  // {stall_len[42:35], status[34:32], result[31:0]}
  logic [42:0] exp_q[$];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural multdiv unit ----------------
  int          mdl_delay = 0;   // RDY this many cycles after the start pulse; 0 = never
  logic        mdl_exc   = 1'b0;
  int          mdl_cnt   = 0;
  logic        mdl_go_m, mdl_go_d, mdl_is_div;
  logic [31:0] mdl_a, mdl_b, smp_a, smp_b;

  always @(posedge clock) begin
    mdl_go_m = ctrl_MULT;
    mdl_go_d = ctrl_DIV;
    smp_a    = unit_A;
    smp_b    = unit_B;
    #1;
    if (!reset) begin
      mdl_cnt = 0;
    end else if (mdl_go_m || mdl_go_d) begin
      mdl_is_div = mdl_go_d;
      mdl_a      = smp_a;
      mdl_b      = smp_b;
      mdl_cnt    = mdl_delay;
    end else if (mdl_cnt > 0) begin
      mdl_cnt--;
    end
    unit_resultRDY = reset && (mdl_cnt == 1);
    unit_exception = unit_resultRDY && mdl_exc;
    if (!unit_resultRDY)   unit_result = 32'hDEAD_BEEF;
    else if (!mdl_is_div)  unit_result = mdl_a * mdl_b;
    else if (mdl_b == 0)   unit_result = 32'hFFFF_FFFF;
    else                   unit_result = mdl_a / mdl_b;
  end

  // ---------------- monitor ----------------
  int run = 0, last_run = 0;
  int n_mpulse = 0, n_dpulse = 0, rv_count = 0;
  int last_pulse_cyc = 0, last_done_cyc = 0;
  logic [42:0] e;

  always @(negedge clock) begin
    if (stall) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    if (ctrl_MULT) n_mpulse++;
    if (ctrl_DIV)  n_dpulse++;
    if (ctrl_MULT || ctrl_DIV) last_pulse_cyc = cyc;
    if (result_valid) begin
      rv_count++;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result_valid: got result 0x%0h status %0d, expected no result", result, result_status);
      end else begin
        e = exp_q.pop_front();
        check("result",        64'(result),        64'(e[31:0]));
        check("result_status", 64'(result_status), 64'(e[34:32]));
        check("stall_cycles",  64'(last_run),      64'(e[42:35]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clock);
      if (result_valid) break;
      n++;
    end
    if (n >= budget) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_result_valid: got no result_valid in %0d cycles, expected one", budget);
      if (exp_q.size() != 0) void'(exp_q.pop_back());
    end
    @(posedge clock);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the IDLE cycle after DONE.
  task automatic do_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                       input int delay, input logic exc,
                       input logic [31:0] exp_res, input logic [2:0] exp_st, input int exp_stall);
    int m0, d0;
    m0 = n_mpulse;
    d0 = n_dpulse;
    exp_q.push_back({8'(exp_stall), exp_st, exp_res});
    mdl_delay  = delay;
    mdl_exc    = exc;
    dx_valid   = 1'b1;
    dx_is_mult = !is_div;
    dx_is_div  = is_div;
    operand_a  = a;
    operand_b  = b;
    wait_done(80);
    dx_valid   = 1'b0;
    dx_is_mult = 1'b0;
    dx_is_div  = 1'b0;
    check("mult_pulses", 64'(n_mpulse - m0), is_div ? 64'd0 : 64'd1);
    check("div_pulses",  64'(n_dpulse - d0), is_div ? 64'd1 : 64'd0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int m0, d0, rv0, done1;

  initial begin
    dx_valid = 1'b1; dx_is_mult = 1'b1; dx_is_div = 1'b0; flush = 1'b0;
    operand_a = 32'h1111_2222; operand_b = 32'h3333_4444;
    unit_result = 32'h0; unit_exception = 1'b0; unit_resultRDY = 1'b0;

    // Reset state with a mul presented: stall must still be forced low
    #12;
    check("rst_stall",   64'(stall),         64'd0);
    check("rst_mult",    64'(ctrl_MULT),     64'd0);
    check("rst_div",     64'(ctrl_DIV),      64'd0);
    check("rst_unit_a",  64'(unit_A),        64'd0);
    check("rst_unit_b",  64'(unit_B),        64'd0);
    check("rst_valid",   64'(result_valid),  64'd0);
    check("rst_result",  64'(result),        64'd0);
    check("rst_status",  64'(result_status), 64'd0);
    check("rst_state",   64'(dbg_state),     64'(IDLE));
    dx_valid = 1'b0; dx_is_mult = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    idle_cycles(2);

    // mul 7x6, RDY after 16 cycles: stall 18
    do_op(1'b0, 32'd7, 32'd6, 16, 1'b0, 32'd42, STAT_OK, 18);
    idle_cycles(2);
    // div 100/0 with exception
    do_op(1'b1, 32'd100, 32'd0, 5, 1'b1, 32'hFFFF_FFFF, STAT_DIV, 7);
    idle_cycles(2);
    // unit never answers: timeout after MAX_CYCLES BUSY cycles
    do_op(1'b0, 32'd1234, 32'd0, 0, 1'b0, 32'd0, STAT_TIMEOUT, 42);
    idle_cycles(2);

    // back-to-back mul then div, one IDLE cycle between them
    do_op(1'b0, 32'd3, 32'd5, 2, 1'b0, 32'd15, STAT_OK, 4);
    done1 = last_done_cyc;
    do_op(1'b1, 32'd100, 32'd7, 4, 1'b0, 32'd14, STAT_OK, 6);
    check("b2b_gap", 64'(last_pulse_cyc - done1), 64'd2);
    idle_cycles(2);

    // RDY one cycle after the pulse
    do_op(1'b0, 32'd9, 32'd9, 1, 1'b0, 32'd81, STAT_OK, 3);
    idle_cycles(2);
    // RDY on the last allowed BUSY cycle wins over the timeout
    do_op(1'b1, 32'd1000, 32'd10, 40, 1'b0, 32'd100, STAT_OK, 42);
    idle_cycles(2);
    // RDY one cycle too late: timeout
    do_op(1'b0, 32'd5, 32'd5, 41, 1'b0, 32'd0, STAT_TIMEOUT, 42);
    idle_cycles(3);
    // mul overflow
    do_op(1'b0, 32'h7FFF_FFFF, 32'd2, 3, 1'b1, 32'hFFFF_FFFE, STAT_MULT, 5);
    idle_cycles(2);

    // flush during BUSY
    m0 = n_mpulse; rv0 = rv_count;
    mdl_delay = 20; mdl_exc = 1'b0;
    dx_valid = 1'b1; dx_is_mult = 1'b1; operand_a = 32'd11; operand_b = 32'd12;
    idle_cycles(3);
    check("flush_pre_state", 64'(dbg_state), 64'(BUSY));
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; dx_valid = 1'b0; dx_is_mult = 1'b0;
    check("flush_stall", 64'(stall),     64'd0);
    check("flush_state", 64'(dbg_state), 64'(IDLE));
    idle_cycles(25);
    check("flush_no_valid",    64'(rv_count - rv0), 64'd0);
    check("flush_mult_pulses", 64'(n_mpulse - m0),  64'd1);

    // reset mid-BUSY; previous result must still be held beforehand
    mdl_delay = 30;
    dx_valid = 1'b1; dx_is_div = 1'b1; operand_a = 32'd50; operand_b = 32'd5;
    idle_cycles(4);
    check("hold_result", 64'(result),        64'hFFFF_FFFE);
    check("hold_status", 64'(result_status), 64'(STAT_MULT));
    check("rst2_pre_state", 64'(dbg_state),  64'(BUSY));
    #2;
    reset = 1'b0;
    #1;
    check("rst2_stall",  64'(stall),         64'd0);
    check("rst2_mult",   64'(ctrl_MULT),     64'd0);
    check("rst2_div",    64'(ctrl_DIV),      64'd0);
    check("rst2_unit_a", 64'(unit_A),        64'd0);
    check("rst2_unit_b", 64'(unit_B),        64'd0);
    check("rst2_valid",  64'(result_valid),  64'd0);
    check("rst2_result", 64'(result),        64'd0);
    check("rst2_status", 64'(result_status), 64'd0);
    check("rst2_state",  64'(dbg_state),     64'(IDLE));
    m0 = n_mpulse; d0 = n_dpulse; rv0 = rv_count;
    idle_cycles(1);
    dx_valid = 1'b0; dx_is_div = 1'b0;
    idle_cycles(2);
    reset = 1'b1;
    idle_cycles(10);
    check("rst2_no_mult_pulse", 64'(n_mpulse - m0), 64'd0);
    check("rst2_no_div_pulse",  64'(n_dpulse - d0), 64'd0);
    check("rst2_no_valid",      64'(rv_count - rv0), 64'd0);
    check("rst2_post_state",    64'(dbg_state),      64'(IDLE));
    check("rst2_post_stall",    64'(stall),          64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
